// File: rtl/cache_pkg.sv
// Shared constants, state encoding and address-field helpers for the
// direct-mapped read cache.
package cache_pkg;

    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 32;
    localparam int INDEX_W  = 6;
    localparam int OFFSET_W = 2;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES    = 1 << INDEX_W;
    localparam int RAM_AW   = INDEX_W + OFFSET_W;

    // One-hot controller states.
    localparam logic [4:0] ST_IDLE     = 5'b00001;
    localparam logic [4:0] ST_LOOKUP   = 5'b00010;
    localparam logic [4:0] ST_MISS_REQ = 5'b00100;
    localparam logic [4:0] ST_REFILL   = 5'b01000;
    localparam logic [4:0] ST_RESP     = 5'b10000;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

    // Address of word 0 of the line containing a.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_data_ram.sv
// Cache data array: one synchronous write port, one synchronous read port
// with a single cycle of read latency.
module cache_data_ram
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RAM_AW-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [1 << RAM_AW];

    // Registered write and registered read of the array.
    // NOTE: the array has no reset; line validity lives in the controller's
    // valid flops, so stale contents are never returned. Non-blocking
    // assignments keep read-before-write ordering well defined.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dm_cache_read_ctrl.sv
// Read-only direct-mapped cache controller: tag/valid lookup, 4-beat line
// refill from memory on miss, fixed-latency hit response, hit/miss counters.
module dm_cache_read_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_valid,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_req_ready,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_data,
    output logic              cache_hit,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    logic [4:0]          state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [OFFSET_W-1:0] beat_q;
    logic                hit_flag_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [15:0]         hit_cnt_q;
    logic [15:0]         miss_cnt_q;
    logic [TAG_W-1:0]    tag_q [LINES];
    logic [LINES-1:0]    valid_q;

    logic                lookup_hit;
    logic                refill_beat;
    logic                last_beat;
    logic                ram_we;
    logic [RAM_AW-1:0]   ram_waddr;
    logic [RAM_AW-1:0]   ram_raddr;
    logic [DATA_W-1:0]   ram_rdata;

    assign lookup_hit  = valid_q[addr_index(addr_q)] &&
                         (tag_q[addr_index(addr_q)] == addr_tag(addr_q));
    assign refill_beat = (state_q == ST_REFILL) && mem_data_valid;
    assign last_beat   = refill_beat && (beat_q == '1);

    // Beats are only written while refilling; stray beats elsewhere are dropped.
    assign ram_we    = refill_beat;
    assign ram_waddr = {addr_index(addr_q), beat_q};
    // The read is issued from the live request address in the accept cycle,
    // so the word is available in LOOKUP.
    assign ram_raddr = {addr_index(cpu_req_addr), addr_offset(cpu_req_addr)};

    cache_data_ram u_data_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (mem_data),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Request sequencing: accept, lookup, refill burst, response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            beat_q      <= '0;
            hit_flag_q  <= 1'b0;
            resp_data_q <= '0;
            mem_addr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req_valid) begin
                        addr_q  <= cpu_req_addr;
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (lookup_hit) begin
                        resp_data_q <= ram_rdata;
                        hit_flag_q  <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        hit_flag_q  <= 1'b0;
                        mem_addr_q  <= line_addr(addr_q);
                        state_q     <= ST_MISS_REQ;
                    end
                end
                ST_MISS_REQ: begin
                    beat_q  <= '0;
                    state_q <= ST_REFILL;
                end
                ST_REFILL: begin
                    if (mem_data_valid) begin
                        if (beat_q == addr_offset(addr_q)) begin
                            resp_data_q <= mem_data;
                        end
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == '1) begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Valid bits: cleared together on reset, set only when a refill completes,
    // so an aborted burst leaves the line invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (last_beat) begin
            valid_q[addr_index(addr_q)] <= 1'b1;
        end
    end

    // Tags need no reset because the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (last_beat) begin
            tag_q[addr_index(addr_q)] <= addr_tag(addr_q);
        end
    end

    // Saturating hit/miss statistics, updated on the lookup outcome.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == ST_LOOKUP) begin
            if (lookup_hit) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign cpu_req_ready  = (state_q == ST_IDLE);
    assign cpu_resp_valid = (state_q == ST_RESP);
    assign cache_hit      = (state_q == ST_RESP) && hit_flag_q;
    assign cpu_resp_data  = resp_data_q;
    assign mem_rd_req     = (state_q == ST_MISS_REQ);
    assign mem_rd_addr    = mem_addr_q;
    assign hit_count      = hit_cnt_q;
    assign miss_count     = miss_cnt_q;

endmodule

// File: tb/tb_dm_cache_read_ctrl.sv
// Directed bench for dm_cache_read_ctrl: a table of read transactions with
// hand-derived outcomes, plus sequences for stray beats, reset mid-refill
// and counter saturation.
module tb_dm_cache_read_ctrl;
    import cache_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req_valid;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic              cpu_req_ready;
    logic              cpu_resp_valid;
    logic [DATA_W-1:0] cpu_resp_data;
    logic              cache_hit;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_data;
    logic [15:0]       hit_count;
    logic [15:0]       miss_count;

    dm_cache_read_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_data  (cpu_resp_data),
        .cache_hit      (cache_hit),
        .mem_rd_req     (mem_rd_req),
        .mem_rd_addr    (mem_rd_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data       (mem_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] addr;
        logic        hit;
        int          gap;
        logic [15:0] hits;
        logic [15:0] misses;
        logic [31:0] data;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: every word carries its own address.
    function automatic logic [31:0] mem_word(input logic [12:0] a);
        return 32'hC0DE_0000 | {19'd0, a};
    endfunction

    // Accept a request at an IDLE negedge; returns at the LOOKUP negedge.
    task automatic start_req(input logic [12:0] a);
        @(negedge clk);
        check("ready_before_req", 32'(cpu_req_ready), 32'd1);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = a;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        check("lookup_no_resp", 32'(cpu_resp_valid), 32'd0);
        check("lookup_not_ready", 32'(cpu_req_ready), 32'd0);
    endtask

    task automatic feed_beats(input logic [12:0] line, input int gap, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            for (int g = 0; g < gap; g++) begin
                mem_data_valid = 1'b0;
                @(negedge clk);
            end
            mem_data_valid = 1'b1;
            mem_data       = mem_word(line + 13'(b));
            @(negedge clk);
            mem_data_valid = 1'b0;
            mem_data       = '0;
            if (b < 3) check("no_early_resp", 32'(cpu_resp_valid), 32'd0);
        end
    endtask

    task automatic do_read(input vec_t v);
        logic [12:0] line;
        line = {v.addr[12:2], 2'b00};
        start_req(v.addr);
        @(negedge clk);
        if (v.hit) begin
            check("hit_no_memreq", 32'(mem_rd_req), 32'd0);
            check("hit_resp_at_2", 32'(cpu_resp_valid), 32'd1);
        end else begin
            check("miss_memreq", 32'(mem_rd_req), 32'd1);
            check("miss_memaddr", 32'(mem_rd_addr), 32'(line));
            check("miss_no_resp", 32'(cpu_resp_valid), 32'd0);
            @(negedge clk);
            check("memreq_one_cycle", 32'(mem_rd_req), 32'd0);
            check("memaddr_held", 32'(mem_rd_addr), 32'(line));
            feed_beats(line, v.gap, 4);
            check("miss_resp_after_last", 32'(cpu_resp_valid), 32'd1);
        end
        check("cache_hit", 32'(cache_hit), 32'(v.hit));
        check("resp_data", cpu_resp_data, v.data);
        check("hit_count", 32'(hit_count), 32'(v.hits));
        check("miss_count", 32'(miss_count), 32'(v.misses));
    endtask

    function automatic vec_t mk(input logic [12:0] a, input logic h, input int g,
                                input logic [15:0] hc, input logic [15:0] mc);
        vec_t v;
        v.addr   = a;
        v.hit    = h;
        v.gap    = g;
        v.hits   = hc;
        v.misses = mc;
        v.data   = mem_word(a);
        return v;
    endfunction

    vec_t vecs[10];

    initial begin
        vecs[0] = mk(13'h0005, 1'b0, 0, 16'd0, 16'd1);  // cold miss, line 0x0004
        vecs[1] = mk(13'h0006, 1'b1, 0, 16'd1, 16'd1);  // hit in same line
        vecs[2] = mk(13'h0105, 1'b0, 0, 16'd1, 16'd2);  // conflict, tag 1 index 1
        vecs[3] = mk(13'h0005, 1'b0, 0, 16'd1, 16'd3);  // evicted, misses again
        vecs[4] = mk(13'h0007, 1'b1, 0, 16'd2, 16'd3);
        vecs[5] = mk(13'h0040, 1'b0, 3, 16'd2, 16'd4);  // gapped burst, offset 0
        vecs[6] = mk(13'h1FFF, 1'b0, 3, 16'd2, 16'd5);  // top address, offset 3
        vecs[7] = mk(13'h1FFC, 1'b1, 0, 16'd3, 16'd5);
        vecs[8] = mk(13'h0043, 1'b1, 0, 16'd4, 16'd5);
        vecs[9] = mk(13'h0105, 1'b0, 0, 16'd4, 16'd6);  // evicted by 0x0005

        reset          = 1'b1;
        cpu_req_valid  = 1'b0;
        cpu_req_addr   = '0;
        mem_data_valid = 1'b0;
        mem_data       = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("rst_ready", 32'(cpu_req_ready), 32'd1);
        check("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        check("rst_cache_hit", 32'(cache_hit), 32'd0);
        check("rst_mem_req", 32'(mem_rd_req), 32'd0);
        check("rst_resp_data", cpu_resp_data, 32'd0);
        check("rst_mem_addr", 32'(mem_rd_addr), 32'd0);
        check("rst_hits", 32'(hit_count), 32'd0);
        check("rst_misses", 32'(miss_count), 32'd0);

        for (int i = 0; i < 10; i++) do_read(vecs[i]);

        // Stray beats while idle must not change state or RAM contents.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            mem_data_valid = 1'b1;
            mem_data       = 32'hDEAD_BEEF;
            @(negedge clk);
            check("stray_ready", 32'(cpu_req_ready), 32'd1);
            check("stray_no_resp", 32'(cpu_resp_valid), 32'd0);
        end
        mem_data_valid = 1'b0;
        mem_data       = '0;
        do_read(mk(13'h0040, 1'b1, 0, 16'd5, 16'd6));
        do_read(mk(13'h0041, 1'b1, 0, 16'd6, 16'd6));

        // Reset after two refill beats aborts the burst.
        start_req(13'h0209);
        @(negedge clk);
        check("abort_memreq", 32'(mem_rd_req), 32'd1);
        @(negedge clk);
        feed_beats(13'h0208, 0, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", 32'(cpu_req_ready), 32'd1);
        check("abort_resp_valid", 32'(cpu_resp_valid), 32'd0);
        check("abort_resp_data", cpu_resp_data, 32'd0);
        check("abort_mem_addr", 32'(mem_rd_addr), 32'd0);
        check("abort_hits", 32'(hit_count), 32'd0);
        check("abort_misses", 32'(miss_count), 32'd0);
        do_read(mk(13'h0005, 1'b0, 0, 16'd0, 16'd1));
        do_read(mk(13'h0209, 1'b0, 1, 16'd0, 16'd2));

        // Saturation: preload the hit counter near its limit, then keep hitting.
        @(negedge clk);
        force dut.hit_cnt_q = 16'hFFFD;
        #1;
        release dut.hit_cnt_q;
        do_read(mk(13'h0005, 1'b1, 0, 16'hFFFE, 16'd2));
        do_read(mk(13'h0006, 1'b1, 0, 16'hFFFF, 16'd2));
        do_read(mk(13'h0007, 1'b1, 0, 16'hFFFF, 16'd2));
        do_read(mk(13'h0004, 1'b1, 0, 16'hFFFF, 16'd2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
